issue_stage: RTL and testbench
==============================

ISSUE_STAGE -- requirements
Module: issue_stage

Interface
REQ-001 Parameter OP_W, default 6: width of the opaque operation code passed from decode to execute.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 flush_i  in  1  kill the held instruction and block acceptance this cycle.
REQ-005 id_valid_i / id_ready_o  in/out  1/1  decode-side handshake; transfer when both are high.
REQ-006 id_op_i, id_pc_i, id_imm_i  in  OP_W/32/32  instruction payload.
REQ-007 id_rs1_i, id_rs2_i, id_rd_i  in  5 each  source and destination register indices.
REQ-008 id_rs1v_i, id_rs2v_i, id_rdv_i  in  1 each  source-used and destination-written flags.
REQ-009 r0_o, r1_o / r0v_o, r1v_o  out  5 / 1  register-file read indices and valids, driven combinationally from id_rs*.
REQ-010 r_opr0_i, r_opr1_i  in  32  register-file read data.
REQ-011 reserved_flg_i  in  1  register file reports a pending write on a used source.
REQ-012 rd_o / reserve_flg_o  out  5 / 1  reservation request to the register file.
REQ-013 wb_i / wb_r_i  in  1 / 5  writeback snoop: the same signals that drive the register-file write port.
REQ-014 ex_valid_o / ex_ready_i  out/in  1/1  execute-side handshake.
REQ-015 ex_op_o, ex_pc_o, ex_imm_o, ex_opr0_o, ex_opr1_o, ex_rd_o, ex_rdv_o  out  OP_W/32/32/32/32/5/1  registered issue bundle.
REQ-016 stall_cnt_o  out  16  saturating count of hazard-stall cycles.

Function
REQ-017 The block SHALL hold one instruction in an output register with states EMPTY (ex_valid_o=0) and FULL (ex_valid_o=1).
REQ-018 Local hazard SHALL equal FULL && ex_rdv_o && ex_rd_o!=0 && ((id_rs1v_i && id_rs1_i==ex_rd_o) || (id_rs2v_i && id_rs2_i==ex_rd_o)).
REQ-019 id_ready_o SHALL be !flush_i && !reserved_flg_i && !local hazard && (EMPTY || (ex_valid_o && ex_ready_i && !waw_block)).
REQ-020 On acceptance the block SHALL capture the payload, r_opr0_i, r_opr1_i, id_rd_i and id_rdv_i into the output register; latency is 1 cycle from acceptance to ex_valid_o.
REQ-021 The output register SHALL be stable while ex_valid_o && !ex_ready_i.
REQ-022 waw_block SHALL equal wb_i && wb_r_i==ex_rd_o && ex_rdv_o && ex_rd_o!=0.
REQ-023 Handoff to execute SHALL occur only when ex_valid_o && ex_ready_i && !waw_block; while waw_block is high, the handoff SHALL be deferred and ex_valid_o SHALL stay high.
REQ-024 reserve_flg_o SHALL be high exactly in handoff cycles with ex_rdv_o && ex_rd_o!=0; rd_o SHALL always equal ex_rd_o.
REQ-025 No reservation SHALL ever be requested for x0.
REQ-026 On flush_i the state SHALL go to EMPTY at the next edge, no reservation SHALL be issued that cycle, and nothing SHALL be accepted that cycle.
REQ-027 Transitions: EMPTY->FULL on acceptance; FULL->EMPTY on handoff without acceptance; FULL->FULL on handoff plus acceptance, or when held; any state->EMPTY on flush_i.
REQ-028 stall_cnt_o SHALL increment when id_valid_i && !flush_i && (reserved_flg_i || local hazard), and SHALL saturate at 16'hFFFF.

Reset
REQ-029 While rst=0 the block SHALL force: state EMPTY, ex_valid_o=0, all ex_* data=0, stall_cnt_o=0, and reserve_flg_o=0.
REQ-030 Reset asserted mid-handshake SHALL discard the held instruction without issuing a reservation.

Structure
REQ-031 OP_W and the EMPTY/FULL state encoding SHALL live in a shared core package used by decode, issue and execute.
REQ-032 The block SHALL be a single module with no sub-modules; the stall counter SHALL remain inline.

Verification
REQ-033 Back-to-back dependent pair: add x5 then use of x5 -> the second instruction is not accepted while the first is held; after handoff reserve_flg_o=1 with rd_o=5, and the second stalls until a writeback to x5.
REQ-034 Writeback conflict: held instruction writes x7 and ex_ready_i=1 while wb_i=1, wb_r_i=7 -> handoff is deferred one cycle; reserve_flg_o rises the following cycle.
REQ-035 Destination x0: instruction with id_rd_i=0, id_rdv_i=1 -> reserve_flg_o stays 0 at handoff, and a following reader of x0 issues with no stall.
REQ-036 Backpressure: ex_ready_i=0 for 4 cycles -> ex_* is stable and id_ready_o=0; on ex_ready_i=1 handoff and a new acceptance occur in the same cycle.
REQ-037 Flush while FULL -> ex_valid_o=0 next cycle, no reserve_flg_o pulse, and id_ready_o=0 in the flush cycle.
REQ-038 Saturation: hold reserved_flg_i=1 with id_valid_i=1 for 70000 cycles -> stall_cnt_o=16'hFFFF; reset -> stall_cnt_o=0.

Source files
------------

// File: rtl/issue_stage_pkg.sv
// Shared core definitions for decode, issue and execute.
// Latency: n/a (constants, types and helpers only).
// Backpressure: n/a.
package issue_stage_pkg;

  // Width of the opaque operation code carried from decode to execute.
  localparam int CORE_OP_W = 6;

  // Issue register occupancy encoding.
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  localparam int              STALL_W   = 16;
  localparam logic [STALL_W-1:0] STALL_MAX = '1;

  typedef logic [4:0] reg_idx_t;

  // x0 is hardwired, so it is never a real producer or consumer.
  function automatic logic reg_live(input logic vld, input reg_idx_t idx);
    return vld && (idx != 5'd0);
  endfunction

endpackage

// File: rtl/issue_stage_if.sv
// Decode-to-issue and issue-to-execute handshake plus payload bundle.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both sides; master drives decode side, slave is the issue stage.
interface issue_stage_if
  import issue_stage_pkg::*;
#(
  parameter int OP_W = CORE_OP_W
);
  // decode side
  logic            id_valid_i;
  logic            id_ready_o;
  logic [OP_W-1:0] id_op_i;
  logic [31:0]     id_pc_i;
  logic [31:0]     id_imm_i;
  reg_idx_t        id_rs1_i;
  reg_idx_t        id_rs2_i;
  reg_idx_t        id_rd_i;
  logic            id_rs1v_i;
  logic            id_rs2v_i;
  logic            id_rdv_i;
  // execute side
  logic            ex_valid_o;
  logic            ex_ready_i;
  logic [OP_W-1:0] ex_op_o;
  logic [31:0]     ex_pc_o;
  logic [31:0]     ex_imm_o;
  logic [31:0]     ex_opr0_o;
  logic [31:0]     ex_opr1_o;
  reg_idx_t        ex_rd_o;
  logic            ex_rdv_o;

  modport master (
    output id_valid_i, id_op_i, id_pc_i, id_imm_i,
           id_rs1_i, id_rs2_i, id_rd_i, id_rs1v_i, id_rs2v_i, id_rdv_i,
           ex_ready_i,
    input  id_ready_o, ex_valid_o, ex_op_o, ex_pc_o, ex_imm_o,
           ex_opr0_o, ex_opr1_o, ex_rd_o, ex_rdv_o
  );

  modport slave (
    input  id_valid_i, id_op_i, id_pc_i, id_imm_i,
           id_rs1_i, id_rs2_i, id_rd_i, id_rs1v_i, id_rs2v_i, id_rdv_i,
           ex_ready_i,
    output id_ready_o, ex_valid_o, ex_op_o, ex_pc_o, ex_imm_o,
           ex_opr0_o, ex_opr1_o, ex_rd_o, ex_rdv_o
  );

endinterface

// File: rtl/issue_stage.sv
// Single-entry issue register between decode and execute with RAW/WAW interlocks and reservation requests.
// Latency: 1 cycle from decode acceptance to ex_valid_o.
// Backpressure: holds while execute is not ready or a writeback to the held rd is in flight; refuses decode on hazards or flush.
module issue_stage
  import issue_stage_pkg::*;
#(
  parameter int OP_W = CORE_OP_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush_i,
  issue_stage_if.slave        bus,
  output reg_idx_t            r0_o,
  output reg_idx_t            r1_o,
  output logic                r0v_o,
  output logic                r1v_o,
  input  logic [31:0]         r_opr0_i,
  input  logic [31:0]         r_opr1_i,
  input  logic                reserved_flg_i,
  output reg_idx_t            rd_o,
  output logic                reserve_flg_o,
  input  logic                wb_i,
  input  reg_idx_t            wb_r_i,
  output logic [STALL_W-1:0]  stall_cnt_o
);

  logic [0:0]         r_state;
  logic [OP_W-1:0]    r_op;
  logic [31:0]        r_pc;
  logic [31:0]        r_imm;
  logic [31:0]        r_opr0;
  logic [31:0]        r_opr1;
  reg_idx_t           r_rd;
  logic               r_rdv;
  logic [STALL_W-1:0] r_stall_cnt;

  logic w_full;
  logic w_rd_live;
  logic w_local_haz;
  logic w_waw_block;
  logic w_handoff;
  logic w_id_ready;
  logic w_accept;
  logic w_stall;

  assign w_full    = (r_state == ST_FULL);
  assign w_rd_live = reg_live(r_rdv, r_rd);

  // Younger instruction reads the register the held one is about to write.
  assign w_local_haz = w_full && w_rd_live &&
                       ((bus.id_rs1v_i && bus.id_rs1_i == r_rd) ||
                        (bus.id_rs2v_i && bus.id_rs2_i == r_rd));

  // A writeback retiring the same rd this cycle would clear a reservation we are about to set.
  assign w_waw_block = wb_i && (wb_r_i == r_rd) && w_rd_live;
  assign w_handoff   = w_full && bus.ex_ready_i && !w_waw_block;

  assign w_id_ready = !flush_i && !reserved_flg_i && !w_local_haz &&
                      (!w_full || w_handoff);
  assign w_accept   = bus.id_valid_i && w_id_ready;
  assign w_stall    = bus.id_valid_i && !flush_i && (reserved_flg_i || w_local_haz);

  assign bus.id_ready_o = w_id_ready;
  assign bus.ex_valid_o = w_full;
  assign bus.ex_op_o    = r_op;
  assign bus.ex_pc_o    = r_pc;
  assign bus.ex_imm_o   = r_imm;
  assign bus.ex_opr0_o  = r_opr0;
  assign bus.ex_opr1_o  = r_opr1;
  assign bus.ex_rd_o    = r_rd;
  assign bus.ex_rdv_o   = r_rdv;

  assign r0_o  = bus.id_rs1_i;
  assign r1_o  = bus.id_rs2_i;
  assign r0v_o = bus.id_rs1v_i;
  assign r1v_o = bus.id_rs2v_i;

  // A flushed instruction never reserves its destination.
  assign rd_o          = r_rd;
  assign reserve_flg_o = w_handoff && w_rd_live && !flush_i;

  assign stall_cnt_o = r_stall_cnt;

  // Occupancy: flush wins, acceptance refills, handoff alone drains.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_EMPTY;
    end else if (flush_i) begin
      r_state <= ST_EMPTY;
    end else if (w_accept) begin
      r_state <= ST_FULL;
    end else if (w_handoff) begin
      r_state <= ST_EMPTY;
    end
  end

  // Issue bundle captured only on acceptance so it holds steady under backpressure.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op   <= '0;
      r_pc   <= '0;
      r_imm  <= '0;
      r_opr0 <= '0;
      r_opr1 <= '0;
      r_rd   <= '0;
      r_rdv  <= 1'b0;
    end else if (w_accept) begin
      r_op   <= bus.id_op_i;
      r_pc   <= bus.id_pc_i;
      r_imm  <= bus.id_imm_i;
      r_opr0 <= r_opr0_i;
      r_opr1 <= r_opr1_i;
      r_rd   <= bus.id_rd_i;
      r_rdv  <= bus.id_rdv_i;
    end
  end

  // Saturating count of cycles a valid decode slot was held back by a hazard.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall && r_stall_cnt != STALL_MAX) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_issue_stage.sv
// Directed bench for issue_stage: interlocks, writeback deferral, x0, backpressure, flush, reset, saturation.
// Latency: n/a.
// Backpressure: bench drives ex_ready_i directly.
module tb_issue_stage;
  import issue_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  reg_idx_t    r0_o, r1_o, rd_o, wb_r_i;
  logic        r0v_o, r1v_o, reserve_flg_o, wb_i, reserved_flg_i;
  logic [31:0] r_opr0_i, r_opr1_i;
  logic [15:0] stall_cnt_o;

  int n_vec = 0;
  int n_err = 0;

  issue_stage_if #(.OP_W(6)) u_bus ();

  issue_stage #(.OP_W(6)) u_dut (
    .clk            (clk),
    .rst            (rst),
    .flush_i        (flush_i),
    .bus            (u_bus),
    .r0_o           (r0_o),
    .r1_o           (r1_o),
    .r0v_o          (r0v_o),
    .r1v_o          (r1v_o),
    .r_opr0_i       (r_opr0_i),
    .r_opr1_i       (r_opr1_i),
    .reserved_flg_i (reserved_flg_i),
    .rd_o           (rd_o),
    .reserve_flg_o  (reserve_flg_o),
    .wb_i           (wb_i),
    .wb_r_i         (wb_r_i),
    .stall_cnt_o    (stall_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Settle combinational outputs after changing inputs mid-cycle.
  task automatic settle();
    #1;
  endtask

  task automatic drive_id(input logic vld, input logic [5:0] op, input logic [31:0] pc,
                          input logic [4:0] rs1, input logic rs1v,
                          input logic [4:0] rs2, input logic rs2v,
                          input logic [4:0] rd, input logic rdv,
                          input logic [31:0] opr0, input logic [31:0] opr1);
    u_bus.id_valid_i = vld;
    u_bus.id_op_i    = op;
    u_bus.id_pc_i    = pc;
    u_bus.id_imm_i   = pc + 32'd4;
    u_bus.id_rs1_i   = rs1;
    u_bus.id_rs1v_i  = rs1v;
    u_bus.id_rs2_i   = rs2;
    u_bus.id_rs2v_i  = rs2v;
    u_bus.id_rd_i    = rd;
    u_bus.id_rdv_i   = rdv;
    r_opr0_i         = opr0;
    r_opr1_i         = opr1;
  endtask

  initial begin
    rst = 1'b0;
    flush_i = 1'b0;
    reserved_flg_i = 1'b0;
    wb_i = 1'b0;
    wb_r_i = 5'd0;
    u_bus.ex_ready_i = 1'b0;
    drive_id(1'b0, 6'd0, 32'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
    repeat (2) tick();

    // Reset state
    chk_eq("rst_ex_valid", u_bus.ex_valid_o, 32'd0);
    chk_eq("rst_ex_pc", u_bus.ex_pc_o, 32'd0);
    chk_eq("rst_stall", stall_cnt_o, 32'd0);
    chk_eq("rst_reserve", reserve_flg_o, 32'd0);
    rst = 1'b1;
    tick();

    // Dependent pair: I1 writes x5, I2 reads x5
    drive_id(1'b1, 6'd1, 32'h100, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 32'd11, 32'd22);
    settle();
    chk_eq("i1_ready", u_bus.id_ready_o, 32'd1);
    chk_eq("i1_r0", r0_o, 32'd1);
    chk_eq("i1_r1v", r1v_o, 32'd1);
    tick();
    chk_eq("i1_ex_valid", u_bus.ex_valid_o, 32'd1);
    chk_eq("i1_ex_rd", u_bus.ex_rd_o, 32'd5);
    chk_eq("i1_ex_opr0", u_bus.ex_opr0_o, 32'd11);
    chk_eq("i1_ex_opr1", u_bus.ex_opr1_o, 32'd22);
    chk_eq("i1_ex_imm", u_bus.ex_imm_o, 32'h104);
    drive_id(1'b1, 6'd2, 32'h104, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 32'd33, 32'd44);
    settle();
    chk_eq("raw_held_ready", u_bus.id_ready_o, 32'd0);
    tick();
    chk_eq("raw_stall1", stall_cnt_o, 32'd1);
    u_bus.ex_ready_i = 1'b1;
    settle();
    chk_eq("raw_handoff_ready", u_bus.id_ready_o, 32'd0);
    chk_eq("raw_reserve", reserve_flg_o, 32'd1);
    chk_eq("raw_rd", rd_o, 32'd5);
    tick();
    chk_eq("raw_drained", u_bus.ex_valid_o, 32'd0);
    chk_eq("raw_stall2", stall_cnt_o, 32'd2);
    reserved_flg_i = 1'b1;
    settle();
    chk_eq("rf_pending_ready", u_bus.id_ready_o, 32'd0);
    tick();
    chk_eq("rf_stall3", stall_cnt_o, 32'd3);
    reserved_flg_i = 1'b0;
    wb_i = 1'b1;
    wb_r_i = 5'd5;
    settle();
    chk_eq("wb_release_ready", u_bus.id_ready_o, 32'd1);
    tick();
    wb_i = 1'b0;
    chk_eq("i2_ex_rd", u_bus.ex_rd_o, 32'd6);
    chk_eq("i2_ex_opr0", u_bus.ex_opr0_o, 32'd33);
    chk_eq("i2_stall", stall_cnt_o, 32'd3);

    // Drain I2 and load I3 writing x7
    drive_id(1'b0, 6'd0, 32'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
    tick();
    chk_eq("i2_drained", u_bus.ex_valid_o, 32'd0);
    u_bus.ex_ready_i = 1'b0;
    drive_id(1'b1, 6'd3, 32'h108, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 32'd1, 32'd2);
    tick();
    chk_eq("i3_ex_rd", u_bus.ex_rd_o, 32'd7);
    // Writeback to x7 in the ready cycle defers the handoff
    drive_id(1'b0, 6'd0, 32'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
    u_bus.ex_ready_i = 1'b1;
    wb_i = 1'b1;
    wb_r_i = 5'd7;
    settle();
    chk_eq("waw_no_reserve", reserve_flg_o, 32'd0);
    tick();
    chk_eq("waw_held_valid", u_bus.ex_valid_o, 32'd1);
    wb_i = 1'b0;
    settle();
    chk_eq("waw_late_reserve", reserve_flg_o, 32'd1);
    chk_eq("waw_rd", rd_o, 32'd7);
    tick();
    chk_eq("i3_drained", u_bus.ex_valid_o, 32'd0);

    // Destination x0 never reserves and never interlocks
    u_bus.ex_ready_i = 1'b0;
    drive_id(1'b1, 6'd4, 32'h10c, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 32'd5, 32'd6);
    tick();
    chk_eq("x0_valid", u_bus.ex_valid_o, 32'd1);
    u_bus.ex_ready_i = 1'b1;
    drive_id(1'b1, 6'd5, 32'h110, 5'd0, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 32'd7, 32'd8);
    settle();
    chk_eq("x0_reserve", reserve_flg_o, 32'd0);
    chk_eq("x0_reader_ready", u_bus.id_ready_o, 32'd1);
    tick();
    chk_eq("i5_ex_rd", u_bus.ex_rd_o, 32'd8);
    chk_eq("x0_stall", stall_cnt_o, 32'd3);

    // Backpressure for 4 cycles, then handoff and accept together
    u_bus.ex_ready_i = 1'b0;
    drive_id(1'b1, 6'd6, 32'h200, 5'd1, 1'b1, 5'd2, 1'b1, 5'd9, 1'b1, 32'd9, 32'd10);
    for (int i = 0; i < 4; i++) begin
      settle();
      chk_eq("bp_ready", u_bus.id_ready_o, 32'd0);
      chk_eq("bp_pc", u_bus.ex_pc_o, 32'h110);
      chk_eq("bp_op", u_bus.ex_op_o, 32'd5);
      tick();
    end
    chk_eq("bp_stall", stall_cnt_o, 32'd3);
    u_bus.ex_ready_i = 1'b1;
    settle();
    chk_eq("bp_release_ready", u_bus.id_ready_o, 32'd1);
    chk_eq("bp_reserve", reserve_flg_o, 32'd1);
    chk_eq("bp_rd", rd_o, 32'd8);
    tick();
    chk_eq("i6_valid", u_bus.ex_valid_o, 32'd1);
    chk_eq("i6_pc", u_bus.ex_pc_o, 32'h200);
    chk_eq("i6_rd", u_bus.ex_rd_o, 32'd9);

    // Flush while FULL
    drive_id(1'b1, 6'd7, 32'h300, 5'd3, 1'b1, 5'd4, 1'b1, 5'd11, 1'b1, 32'd1, 32'd1);
    flush_i = 1'b1;
    settle();
    chk_eq("flush_ready", u_bus.id_ready_o, 32'd0);
    chk_eq("flush_reserve", reserve_flg_o, 32'd0);
    tick();
    flush_i = 1'b0;
    chk_eq("flush_empty", u_bus.ex_valid_o, 32'd0);

    // Reset mid-handshake discards without reserving
    u_bus.ex_ready_i = 1'b0;
    drive_id(1'b1, 6'd8, 32'h400, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 32'd1, 32'd1);
    tick();
    chk_eq("i8_valid", u_bus.ex_valid_o, 32'd1);
    drive_id(1'b0, 6'd0, 32'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
    u_bus.ex_ready_i = 1'b1;
    rst = 1'b0;
    settle();
    chk_eq("arst_valid", u_bus.ex_valid_o, 32'd0);
    chk_eq("arst_reserve", reserve_flg_o, 32'd0);
    chk_eq("arst_rd", u_bus.ex_rd_o, 32'd0);
    tick();
    rst = 1'b1;
    tick();

    // Stall counter saturation
    reserved_flg_i = 1'b1;
    drive_id(1'b1, 6'd9, 32'h500, 5'd1, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 32'd0, 32'd0);
    repeat (70000) @(posedge clk);
    #1;
    chk_eq("sat_stall", stall_cnt_o, 32'h0000ffff);
    rst = 1'b0;
    settle();
    chk_eq("sat_rst_stall", stall_cnt_o, 32'd0);
    reserved_flg_i = 1'b0;
    drive_id(1'b0, 6'd0, 32'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
